panel_io: RTL
=============

# panel_io

Front-panel I/O stage for the Antminer S9 control board, between the PS GPIO of `zynq_bd` and the board pins.
- Consumes the 16-bit `gpio_o` word to drive six LEDs and the beeper with hardware-timed patterns.
- Debounces the two push buttons and returns their state and press events on `gpio_i`.
- Generates the `aux_reset_in` request on a long press of button 1.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: `clk` frequency. Must be an integer multiple of 1000.
- `DEBOUNCE_MS`, 20: consecutive stable 1 ms ticks required before a new button level is accepted.
- `LONG_PRESS_MS`, 3000: debounced hold time of button 1 that triggers the reset request.
- `RST_PULSE_CYC`, 16: width of the `aux_reset_out` pulse, in clock cycles.

Ports:
- `clk`  in  1: single clock (PL fabric clock from the PS).
- `rst`  in  1: reset; synchronous, active-high.
- `gpio_o`  in  16: control word from the PS.
- `gpio_i`  out  8: status word to the PS.
- `buttons_n`  in  2: raw board buttons, asynchronous, active-low. Bit 0 = BUTTONS[1], bit 1 = BUTTONS[2].
- `leds`  out  6: LED drives, active-high.
- `beep`  out  1: beeper drive, active-high.
- `aux_reset_out`  out  1: reset request to the processor-system reset block.

## Operation
- **Tick:** a free-running prescaler emits a 1-cycle `tick` every `CLK_HZ/1000` cycles. A ms counter `ms_cnt` runs 0..999 on ticks and wraps to 0.
- **LED modes:** `gpio_o[2k+1:2k]` sets the mode of LED k (k = 0..5).
  - 00: off.
  - 01: on.
  - 10: 1 Hz blink; on while `ms_cnt < 500`.
  - 11: 4 Hz blink; on while `ms_cnt % 250 < 125`.
  - All LEDs share `ms_cnt`, so blinks are phase-aligned.
- **Beep mode:** `gpio_o[13:12]` sets the beeper mode.
  - 00: off.
  - 01: on.
  - 11: 1 Hz pulse; on while `ms_cnt < 100`.
  - 10: chirp. Entering 10 from any other mode loads a 100-tick countdown, and `beep` is high while the countdown is nonzero. Staying in 10 does not retrigger. Leaving 10 clears the countdown immediately.
- **`gpio_o[14]`:** long-press reset enable.
- **`gpio_o[15]`:** reserved and ignored.
- **Buttons:**
  - Each `buttons_n` bit passes through a 2-FF synchronizer and is inverted to `pressed`.
  - A debouncer counts ticks while the synchronized level differs from the accepted level. After `DEBOUNCE_MS` such ticks it accepts the new level. Any cycle where the level matches the accepted level clears the count.
- **Status word:**
  - `gpio_i[1:0]`: debounced pressed levels.
  - `gpio_i[3:2]`: press toggles; each flips on every accepted 0→1 transition of the matching button. Software detects presses by change, so no clear is needed.
  - `gpio_i[4]`: long-press-fired flag (below).
  - `gpio_i[7:5]`: 0.
- **Long press:**
  - While button 1 is debounced-pressed, a hold counter increments per tick.
  - When it reaches `LONG_PRESS_MS` with `gpio_o[14]=1`, `aux_reset_out` goes high for exactly `RST_PULSE_CYC` cycles and `gpio_i[4]` sets.
  - This fires once per press. The counter saturates and clears on debounced release.
  - `gpio_i[4]` clears on the next debounced press of button 1.
  - If `gpio_o[14]=0` at the threshold, no pulse fires in that press, even if the enable later rises.

## Timing
- **Reset values:** `leds`=0, `beep`=0, `gpio_i`=0, `aux_reset_out`=0. Debounced levels, toggles, prescaler, `ms_cnt`, chirp, hold and pulse counters are all 0.
- **Reset mid-pulse:** an `aux_reset_out` pulse in progress is truncated.
- **Output latency:** LED and beep outputs are registered and reflect a `gpio_o` change 1 cycle later.
  - Blink edges occur 1 cycle after the tick that moves `ms_cnt` across a threshold.
- **Button latency:** a press stable from cycle t appears on `gpio_i` after 2 sync cycles plus `DEBOUNCE_MS` ticks plus 1 register cycle. Exact latency depends on tick phase, with a range of one tick period.
- **Glitches:** bounces shorter than `DEBOUNCE_MS` ticks never change `gpio_i`.
- **Simultaneous events:** both buttons are processed independently in the same cycle.
- **Chirp restart:** a chirp re-entry in the same cycle that the countdown expires restarts the countdown.

## Structure
- **Package `panel_io_pkg`:** holds
  - the `led_mode_t` and `beep_mode_t` 2-bit enums;
  - the `gpio_o` field bit positions;
  - the `gpio_i` field bit positions;
  - the blink and chirp thresholds (500, 250/125, 100).
- **Sub-module `button_debounce`:** synchronizer, debounce counter and accepted level plus rise strobe. Instantiated twice.
- **Top-level placement:** `panel_io` instantiates `button_debounce` and contains the tick, pattern and long-press logic.

## Test plan
Sim parameters: `CLK_HZ`=10_000 (tick every 10 cycles), `DEBOUNCE_MS`=3, `LONG_PRESS_MS`=20, `RST_PULSE_CYC`=16.
- **Reset:** assert `rst` 5 cycles with all inputs toggling → all outputs 0. `gpio_i`=0x00 one cycle after release.
- **LED modes:** `gpio_o[11:0]`=0b11_10_01_00_10_01 →
  - LED0 and LED3 steady on; LED2 off.
  - LED1 and LED4 high for 500 ticks per 1000.
  - LED5 high for 125 ticks per 250.
  - All phase-aligned to `ms_cnt`=0.
- **Chirp:** beep mode 00→10, held 300 ticks → `beep` high exactly 100 ticks. Then 10→00→10 → a second 100-tick burst. Moving 10→00 at tick 50 → `beep` low next cycle.
- **Debounce:**
  - Button 0 bounce of 2-tick pulses → `gpio_i`[0] stays 0.
  - Steady press → `gpio_i`[0]=1 and `gpio_i`[2] toggles 0→1 within 3–4 ticks plus 3 cycles.
  - A second press toggles `gpio_i`[2] back to 0.
- **Long press enabled:** `gpio_o[14]`=1, hold button 0 for 50 ticks → exactly one 16-cycle `aux_reset_out` pulse, 20 ticks after the debounced press, and `gpio_i[4]`=1. Release and re-press → `gpio_i[4]`=0.
- **Long press disabled:** `gpio_o[14]`=0 at the threshold and set to 1 at tick 30 of the same hold → no pulse. Also assert `rst` mid-pulse in a separate run → `aux_reset_out` 0 next cycle.

Source files
------------

// File: rtl/panel_io_pkg.sv
// panel_io_pkg: LED/beep modes, gpio word field positions and pattern thresholds
package panel_io_pkg;
  typedef enum logic [1:0] {
    LED_OFF       = 2'b00,
    LED_ON        = 2'b01,
    LED_BLINK_1HZ = 2'b10,
    LED_BLINK_4HZ = 2'b11
  } led_mode_t;
  typedef enum logic [1:0] {
    BEEP_OFF   = 2'b00,
    BEEP_ON    = 2'b01,
    BEEP_CHIRP = 2'b10,
    BEEP_PULSE = 2'b11
  } beep_mode_t;
  localparam int NUM_LEDS = 6;
  localparam int GO_BEEP = 12;
  localparam int GO_LP_EN = 14;
  localparam int GI_LEVEL = 0;
  localparam int GI_TOGGLE = 2;
  localparam int GI_LP_FIRED = 4;
  localparam int MS_PERIOD = 1000;
  localparam int BLINK_1HZ_ON = 500;
  localparam int BLINK_4HZ_PERIOD = 250;
  localparam int BLINK_4HZ_ON = 125;
  localparam int BEEP_PULSE_ON = 100;
  localparam int CHIRP_TICKS = 100;
  function automatic logic led_on(led_mode_t m, logic [9:0] ms);
    return m == LED_ON ||
           (m == LED_BLINK_1HZ && ms < 10'(BLINK_1HZ_ON)) ||
           (m == LED_BLINK_4HZ && (ms % 10'(BLINK_4HZ_PERIOD)) < 10'(BLINK_4HZ_ON));
  endfunction
endpackage

// File: rtl/panel_io_button_debounce.sv
// button_debounce: 2-FF synchronizer, tick-based debounce and accepted level with rise strobe
module button_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_n,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic pressed, accept;
  always_comb begin
    sync_d = {sync_q[0], btn_n};
    pressed = ~sync_q[1];
    accept = tick && pressed != level_q && cnt_q == CW'(DEBOUNCE_MS - 1);
    cnt_d = (pressed == level_q || accept) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    level_d = accept ? pressed : level_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
    end
  assign level = level_q;
  assign rise = accept && pressed;
endmodule

// File: rtl/panel_io.sv
// panel_io: front-panel LED/beeper pattern generator, button debounce and long-press reset request
module panel_io
  import panel_io_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_PRESS_MS = 3000,
  parameter int RST_PULSE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] gpio_o,
  output logic [7:0]  gpio_i,
  input  logic [1:0]  buttons_n,
  output logic [5:0]  leds,
  output logic        beep,
  output logic        aux_reset_out
);
  localparam int DIV = CLK_HZ / 1000;
  localparam int PW = $clog2(DIV + 1);
  localparam int HW = $clog2(LONG_PRESS_MS + 1);
  localparam int RW = $clog2(RST_PULSE_CYC + 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0] ms_q, ms_d;
  logic [5:0] leds_q, leds_d;
  logic beep_q, beep_d;
  beep_mode_t bmode, bmode_prev_q, bmode_prev_d;
  logic [6:0] chirp_q, chirp_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] pulse_q, pulse_d;
  logic [1:0] toggle_q, toggle_d, level, rise;
  logic lp_q, lp_d, tick, fire;
  logic unused_reserved;
  assign unused_reserved = gpio_o[15];
  for (genvar b = 0; b < 2; b++) begin : g_btn
    button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .btn_n(buttons_n[b]),
      .level(level[b]),
      .rise(rise[b])
    );
  end
  always_comb begin
    tick = pre_q == PW'(DIV - 1);
    pre_d = tick ? '0 : pre_q + 1'b1;
    ms_d = !tick ? ms_q : ms_q == 10'(MS_PERIOD - 1) ? '0 : ms_q + 1'b1;
    leds_d = '0;
    for (int k = 0; k < NUM_LEDS; k++) leds_d[k] = led_on(led_mode_t'(gpio_o[2*k +: 2]), ms_q);
    bmode = beep_mode_t'(gpio_o[GO_BEEP +: 2]);
    bmode_prev_d = bmode;
    // entering chirp reloads even if the previous countdown just expired
    chirp_d = bmode != BEEP_CHIRP ? '0 :
              bmode_prev_q != BEEP_CHIRP ? 7'(CHIRP_TICKS) :
              (tick && chirp_q != '0) ? chirp_q - 1'b1 : chirp_q;
    beep_d = bmode == BEEP_ON || (bmode == BEEP_PULSE && ms_q < 10'(BEEP_PULSE_ON)) ||
             (bmode == BEEP_CHIRP && chirp_d != '0);
    // hold saturates at the threshold, so the threshold is crossed once per press
    hold_d = !level[0] ? '0 : (tick && hold_q != HW'(LONG_PRESS_MS)) ? hold_q + 1'b1 : hold_q;
    fire = tick && level[0] && hold_q == HW'(LONG_PRESS_MS - 1) && gpio_o[GO_LP_EN];
    pulse_d = fire ? RW'(RST_PULSE_CYC) : pulse_q != '0 ? pulse_q - 1'b1 : pulse_q;
    toggle_d = toggle_q ^ rise;
    lp_d = fire || (lp_q && !rise[0]);
    gpio_i = '0;
    gpio_i[GI_LEVEL +: 2] = level;
    gpio_i[GI_TOGGLE +: 2] = toggle_q;
    gpio_i[GI_LP_FIRED] = lp_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pre_q <= '0;
      ms_q <= '0;
      leds_q <= '0;
      beep_q <= 1'b0;
      bmode_prev_q <= BEEP_OFF;
      chirp_q <= '0;
      hold_q <= '0;
      pulse_q <= '0;
      toggle_q <= '0;
      lp_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      ms_q <= ms_d;
      leds_q <= leds_d;
      beep_q <= beep_d;
      bmode_prev_q <= bmode_prev_d;
      chirp_q <= chirp_d;
      hold_q <= hold_d;
      pulse_q <= pulse_d;
      toggle_q <= toggle_d;
      lp_q <= lp_d;
    end
  assign leds = leds_q;
  assign beep = beep_q;
  assign aux_reset_out = pulse_q != '0;
endmodule
